// File: rtl/rega_multizona.sv
// rega_multizona - multi-zone irrigation controller fed by one tank.
//
// Purpose:
//   Debounces the tank level probes into a level (nivel) and an error flag
//   (ERRO), drives the tank inlet valve with hysteresis, raises the alarm,
//   and waters ZONES zones one at a time in round-robin order. Each watering
//   cycle is a timed sprinkler (aspersao) or drip (gotejamento) run followed
//   by a short pause.
//
// Ports:
//   clock       in   system clock
//   reset_n     in   asynchronous active-low reset
//   H, M, L     in   tank level probes high/medium/low, 1 = water present
//   Us          in   per-zone soil dry flag, 1 = dry
//   Ua          in   air humidity high flag
//   T           in   temperature high flag
//   Ve          out  tank inlet valve, 1 = open
//   Al          out  alarm
//   ERRO        out  debounced invalid probe pattern
//   nivel       out  0 critical, 1 low, 2 medium, 3 high
//   Bs          out  sprinkler valve per zone, one-hot or zero
//   Vs          out  drip valve per zone, one-hot or zero
//   zona_ativa  out  zone being watered or last watered
//   ocupado     out  high while a zone is being watered
module rega_multizona #(
  parameter int ZONES    = 4,
  parameter int ZW       = 2,
  parameter int DEBOUNCE = 1000,
  parameter int TICK_DIV = 50000,
  parameter int T_ASP    = 30,
  parameter int T_GOT    = 60,
  parameter int T_PAUSA  = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             H,
  input  logic             M,
  input  logic             L,
  input  logic [ZONES-1:0] Us,
  input  logic             Ua,
  input  logic             T,
  output logic             Ve,
  output logic             Al,
  output logic             ERRO,
  output logic [1:0]       nivel,
  output logic [ZONES-1:0] Bs,
  output logic [ZONES-1:0] Vs,
  output logic [ZW-1:0]    zona_ativa,
  output logic             ocupado
);

  localparam int DW     = $clog2(DEBOUNCE + 1);
  localparam int PW     = $clog2(TICK_DIV);
  localparam int T_RUN  = (T_ASP > T_GOT) ? T_ASP : T_GOT;
  localparam int T_MAX  = (T_RUN > T_PAUSA) ? T_RUN : T_PAUSA;
  localparam int CW     = $clog2(T_MAX + 1);
  localparam logic [ZW:0]   ZONES_X   = (ZW+1)'(ZONES);
  localparam logic [ZW-1:0] ZONE_LAST = ZW'(ZONES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_REGA, S_PAUSA} estado_t;

  // ---------------- level debounce and decode ----------------
  logic [2:0]    w_hml;
  logic [2:0]    r_amostra;
  logic [DW-1:0] r_db_cnt;
  logic [1:0]    r_nivel;
  logic          r_erro;
  logic          r_nivel_ok;  // a first pattern has been accepted since reset

  assign w_hml = {H, M, L};

  // r_db_cnt holds how many consecutive samples matched r_amostra (saturating).
  // Acceptance is driven only by that count, so a pattern that was stable
  // long enough is still taken even if the input moves on the same edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_amostra  <= 3'b000;
      r_db_cnt   <= '0;
      r_nivel    <= 2'd0;
      r_erro     <= 1'b0;
      r_nivel_ok <= 1'b0;
    end else begin
      if (w_hml != r_amostra) begin
        r_amostra <= w_hml;
        r_db_cnt  <= DW'(1);
      end else if (r_db_cnt != DW'(DEBOUNCE)) begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
      if (r_db_cnt == DW'(DEBOUNCE)) begin
        r_nivel_ok <= 1'b1;
        case (r_amostra)
          3'b000:  begin r_nivel <= 2'd0; r_erro <= 1'b0; end
          3'b001:  begin r_nivel <= 2'd1; r_erro <= 1'b0; end
          3'b011:  begin r_nivel <= 2'd2; r_erro <= 1'b0; end
          3'b111:  begin r_nivel <= 2'd3; r_erro <= 1'b0; end
          default: r_erro <= 1'b1;  // nivel keeps its last good value
        endcase
      end
    end
  end

  // ---------------- inlet valve and alarm ----------------
  // Until the first debounced pattern arrives the reset level 0 is not a real
  // measurement, so valve and alarm stay quiet instead of reacting to it.
  logic r_ve;
  logic r_al;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ve <= 1'b0;
      r_al <= 1'b0;
    end else if (r_nivel_ok) begin
      if (r_nivel <= 2'd1 && !r_erro)
        r_ve <= 1'b1;
      else if (r_nivel == 2'd3 || r_erro)
        r_ve <= 1'b0;
      r_al <= r_erro | (r_nivel == 2'd0);
    end
  end

  // ---------------- timing tick ----------------
  logic [PW-1:0] r_pre;
  logic          w_tick;

  assign w_tick = (r_pre == PW'(TICK_DIV - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_pre <= '0;
    else          r_pre <= w_tick ? '0 : r_pre + 1'b1;
  end

  // ---------------- zone search ----------------
  logic          w_perm;
  logic          w_asp;
  logic [ZONES-1:0] w_rot;
  logic          w_found;
  logic [ZW:0]   w_off;
  logic [ZW:0]   w_sum;
  logic [ZW:0]   w_sel_x;
  logic [ZW-1:0] w_sel;
  logic [ZW-1:0] r_ptr;

  assign w_perm = r_nivel_ok & ~r_erro & (r_nivel != 2'd0);
  assign w_asp  = (r_nivel >= 2'd2) & ~T & ~Ua;

  // Rotating by the pointer puts the search start at bit 0; the lowest set
  // bit of w_rot is the first dry zone at or after the pointer.
  assign w_rot = ZONES'({Us, Us} >> r_ptr);

  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int k = ZONES - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_found = 1'b1;
        w_off   = (ZW+1)'(k);
      end
    end
  end

  assign w_sum   = {1'b0, r_ptr} + w_off;
  assign w_sel_x = (w_sum >= ZONES_X) ? w_sum - ZONES_X : w_sum;
  assign w_sel   = w_sel_x[ZW-1:0];

  // ---------------- scheduler FSM ----------------
  estado_t       r_estado, w_estado_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [ZW-1:0] r_zona, w_zona_nxt;
  logic [ZW-1:0] w_ptr_nxt;
  logic          r_asp, w_asp_nxt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_estado <= S_IDLE;
      r_cnt    <= '0;
      r_zona   <= '0;
      r_ptr    <= '0;
      r_asp    <= 1'b0;
    end else begin
      r_estado <= w_estado_nxt;
      r_cnt    <= w_cnt_nxt;
      r_zona   <= w_zona_nxt;
      r_ptr    <= w_ptr_nxt;
      r_asp    <= w_asp_nxt;
    end
  end

  always_comb begin
    w_estado_nxt = r_estado;
    w_cnt_nxt    = r_cnt;
    w_zona_nxt   = r_zona;
    w_ptr_nxt    = r_ptr;
    w_asp_nxt    = r_asp;
    case (r_estado)
      S_IDLE: begin
        if (w_tick && w_perm) w_estado_nxt = S_SELECT;
      end
      S_SELECT: begin
        if (w_found) begin
          w_zona_nxt   = w_sel;
          w_ptr_nxt    = (w_sel == ZONE_LAST) ? '0 : w_sel + 1'b1;
          w_asp_nxt    = w_asp;  // mode is frozen for the whole run
          w_cnt_nxt    = w_asp ? CW'(T_ASP) : CW'(T_GOT);
          w_estado_nxt = S_REGA;
        end else begin
          w_estado_nxt = S_IDLE;
        end
      end
      S_REGA: begin
        // Abort and early stop win over the tick; all exits lead to the pause.
        if (!w_perm || !Us[r_zona]) begin
          w_estado_nxt = S_PAUSA;
          w_cnt_nxt    = CW'(T_PAUSA);
        end else if (w_tick) begin
          if (r_cnt == CW'(1)) begin
            w_estado_nxt = S_PAUSA;
            w_cnt_nxt    = CW'(T_PAUSA);
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
      end
      S_PAUSA: begin
        if (w_tick) begin
          if (r_cnt == CW'(1)) begin
            w_estado_nxt = S_IDLE;
            w_cnt_nxt    = '0;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
      end
      default: w_estado_nxt = S_IDLE;
    endcase
  end

  // ---------------- outputs ----------------
  // Valves decode straight from registered state, so they drop on the same
  // edge that leaves REGA and immediately on an asynchronous reset.
  logic [ZONES-1:0] w_um;
  logic             w_rega;

  assign w_um   = {{(ZONES-1){1'b0}}, 1'b1} << r_zona;
  assign w_rega = (r_estado == S_REGA);

  assign Bs         = (w_rega &&  r_asp) ? w_um : '0;
  assign Vs         = (w_rega && !r_asp) ? w_um : '0;
  assign ocupado    = w_rega;
  assign zona_ativa = r_zona;
  assign nivel      = r_nivel;
  assign ERRO       = r_erro;
  assign Ve         = r_ve;
  assign Al         = r_al;

endmodule
